// File: rtl/cnn_sched_pkg.sv
// Shared definitions for the MAC lane scheduler: FSM encoding, default widths
// and a helper that sizes lane-index fields.
package cnn_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_FINISH   = 2'd3
   } sched_state_e;

   localparam int ADR_W_DEF     = 8;
   localparam int MAC_COUNT_MAX = 8;

   // A single lane still needs a 1-bit index field to keep port widths legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first free requester at or
// after ptr_i, wrapping past N-1 back to 0.
module rr_arbiter #(
   parameter int N     = 1,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     free_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   // Scanning from the farthest offset down lets the closest free lane win last.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no latch is inferred.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (free_i[rot_idx(ptr_i, i)]) begin
            grant_o                  = '0;
            grant_o[rot_idx(ptr_i, i)] = 1'b1;
            idx_o                    = rot_idx(ptr_i, i);
            valid_o                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_lane_scheduler.sv
// Dispatches a latched batch of jobs, one per cycle, onto free MAC lanes and
// retires them from per-lane completion pulses. rst_i is asynchronous, active-low.
module mac_lane_scheduler
   import cnn_sched_pkg::*;
#(
   parameter int MAC_COUNT = 1,
   parameter int ADR_W     = ADR_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADR_W-1:0]     job_count_i,
   input  logic [ADR_W-1:0]     base_x_i,
   input  logic [ADR_W-1:0]     base_y_i,
   input  logic [MAC_COUNT-1:0] lane_done_i,
   output logic [MAC_COUNT-1:0] lane_start_o,
   output logic [ADR_W-1:0]     lane_adr_x_o,
   output logic [ADR_W-1:0]     lane_adr_y_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int IDX_W = idx_width(MAC_COUNT);

   sched_state_e         state_q, state_d;
   logic [MAC_COUNT-1:0] busy_mask_q, busy_mask_d;
   logic [ADR_W-1:0]     issued_q, issued_d;
   logic [ADR_W-1:0]     retired_q, retired_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ADR_W-1:0]     job_count_q, job_count_d;
   logic [ADR_W-1:0]     base_x_q, base_x_d;
   logic [ADR_W-1:0]     base_y_q, base_y_d;
   logic [MAC_COUNT-1:0] lane_start_q, lane_start_d;
   logic [ADR_W-1:0]     adr_x_q, adr_x_d;
   logic [ADR_W-1:0]     adr_y_q, adr_y_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [MAC_COUNT-1:0] grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_valid;

   function automatic logic [ADR_W-1:0] popcount(input logic [MAC_COUNT-1:0] v);
      logic [ADR_W-1:0] c;
      c = '0;
      for (int i = 0; i < MAC_COUNT; i++) c = c + ADR_W'(v[i]);
      return c;
   endfunction

   rr_arbiter #(
      .N     (MAC_COUNT),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .free_i  (~busy_mask_q),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .valid_o (grant_valid)
   );

   always_comb begin
      state_d      = state_q;
      job_count_d  = job_count_q;
      base_x_d     = base_x_q;
      base_y_d     = base_y_q;
      issued_d     = issued_q;
      rr_ptr_d     = rr_ptr_q;
      adr_x_d      = adr_x_q;
      adr_y_d      = adr_y_q;
      lane_start_d = '0;
      done_d       = (state_q == ST_FINISH);
      // Completions on lanes we never dispatched are not counted, only flagged.
      busy_mask_d  = busy_mask_q & ~lane_done_i;
      retired_d    = retired_q + popcount(lane_done_i & busy_mask_q);
      err_d        = err_q | (|(lane_done_i & ~busy_mask_q));

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               job_count_d = job_count_i;
               base_x_d    = base_x_i;
               base_y_d    = base_y_i;
               issued_d    = '0;
               retired_d   = '0;
               err_d       = 1'b0;
               state_d     = (job_count_i == '0) ? ST_FINISH : ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            if (grant_valid) begin
               lane_start_d = grant;
               adr_x_d      = base_x_q + issued_q;
               adr_y_d      = base_y_q;
               busy_mask_d  = busy_mask_d | grant;
               issued_d     = issued_q + ADR_W'(1);
               rr_ptr_d     = (int'(grant_idx) == MAC_COUNT - 1) ? '0 : grant_idx + IDX_W'(1);
               if (issued_d == job_count_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (retired_d == job_count_q) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         busy_mask_q  <= '0;
         issued_q     <= '0;
         retired_q    <= '0;
         rr_ptr_q     <= '0;
         job_count_q  <= '0;
         base_x_q     <= '0;
         base_y_q     <= '0;
         lane_start_q <= '0;
         adr_x_q      <= '0;
         adr_y_q      <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q      <= state_d;
         busy_mask_q  <= busy_mask_d;
         issued_q     <= issued_d;
         retired_q    <= retired_d;
         rr_ptr_q     <= rr_ptr_d;
         job_count_q  <= job_count_d;
         base_x_q     <= base_x_d;
         base_y_q     <= base_y_d;
         lane_start_q <= lane_start_d;
         adr_x_q      <= adr_x_d;
         adr_y_q      <= adr_y_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign lane_start_o = lane_start_q;
   assign lane_adr_x_o = adr_x_q;
   assign lane_adr_y_o = adr_y_q;
   assign busy_o       = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule
